// File: rtl/piso_shift_reader_if.sv
// piso_shift_reader_if
//   Handshake/data bundle for the parallel-load, serial-unload reader.
//   master (producer/consumer side): drives en, D, hold; observes the rest.
//   slave  (piso_shift_reader)      : observes en, D, hold; drives the rest.
//   Signals:
//     en         load request, honoured only while ready=1
//     D          parallel word, sampled on the accepting edge
//     hold       consumer stall, freezes shifting while high
//     ready      reader idle, will accept en
//     sout       current serial bit
//     sout_valid sout is valid and consumed on this edge
//     done       one-cycle pulse after the last bit is consumed
//     Q          copy of the last accepted word
interface piso_shift_reader_if #(
    parameter int unsigned WIDTH = 4
);
    logic             en;
    logic [WIDTH-1:0] D;
    logic             hold;
    logic             ready;
    logic             sout;
    logic             sout_valid;
    logic             done;
    logic [WIDTH-1:0] Q;

    modport master (
        output en, D, hold,
        input  ready, sout, sout_valid, done, Q
    );

    modport slave (
        input  en, D, hold,
        output ready, sout, sout_valid, done, Q
    );
endinterface

// File: rtl/piso_shift_reader.sv
// piso_shift_reader
//   Captures a WIDTH-bit word on an accepted load and drains it one bit per
//   clock on sout, with a hold stall and a done pulse after the last bit.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous, active-low reset
//     bus  piso_shift_reader_if.slave (en, D, hold in; ready, sout,
//          sout_valid, done, Q out)
//   Parameters:
//     WIDTH     word width (>= 2)
//     MSB_FIRST 1: bit WIDTH-1 leaves first; 0: bit 0 leaves first
module piso_shift_reader #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    piso_shift_reader_if.slave    bus
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        unique case (state_q)
            IDLE: begin
                if (bus.en) begin
                    sr_d    = bus.D;
                    q_d     = bus.D;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!bus.hold) begin
                    // Shift toward the output end, zero-filling, so sout
                    // reads 0 once the word has drained.
                    if (MSB_FIRST) begin
                        sr_d = {sr_q[WIDTH-2:0], 1'b0};
                    end else begin
                        sr_d = {1'b0, sr_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
        end
    end

    // Status decodes straight from state so reset clears them immediately.
    assign bus.ready      = (state_q == IDLE);
    assign bus.sout_valid = (state_q == SHIFT) && !bus.hold;
    assign bus.done       = (state_q == DONE);
    assign bus.sout       = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];
    assign bus.Q          = q_q;
endmodule

// File: tb/tb_piso_shift_reader.sv
module tb_piso_shift_reader;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    piso_shift_reader_if #(.WIDTH(4)) m ();
    piso_shift_reader_if #(.WIDTH(4)) l ();

    piso_shift_reader #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
        .clk (clk),
        .rst (rst),
        .bus (m)
    );

    piso_shift_reader #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk (clk),
        .rst (rst),
        .bus (l)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int unsigned n;
        n = 0;
        while (!(m.ready && l.ready) && n < 20) begin
            tick();
            n++;
        end
        n_checks++;
        if (!(m.ready && l.ready)) begin
            n_fail++;
            $display("FAIL idle_timeout: got ready m=%b l=%b exp 1 1", m.ready, l.ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        m.en = 1'b0; m.D = '0; m.hold = 1'b0;
        l.en = 1'b0; l.D = '0; l.hold = 1'b0;
        #3;
        n_checks++; if (m.ready !== 1'b1) begin n_fail++; $display("FAIL por_ready: got %b exp 1", m.ready); end
        n_checks++; if (m.sout !== 1'b0) begin n_fail++; $display("FAIL por_sout: got %b exp 0", m.sout); end
        n_checks++; if (m.sout_valid !== 1'b0) begin n_fail++; $display("FAIL por_valid: got %b exp 0", m.sout_valid); end
        n_checks++; if (m.done !== 1'b0) begin n_fail++; $display("FAIL por_done: got %b exp 0", m.done); end
        n_checks++; if (m.Q !== 4'b0000) begin n_fail++; $display("FAIL por_Q: got %b exp 0000", m.Q); end
        n_checks++; if (l.ready !== 1'b1 || l.Q !== 4'b0000) begin n_fail++; $display("FAIL por_lsb: got ready=%b Q=%b exp 1 0000", l.ready, l.Q); end
        tick();
        tick();
        @(negedge clk);
        rst = 1'b1;
        tick();
        n_checks++; if (m.ready !== 1'b1) begin n_fail++; $display("FAIL rel_ready: got %b exp 1", m.ready); end
    endtask

    task automatic test_reset_mid_shift();
        m.D = 4'b0101; m.en = 1'b1;
        tick();
        m.en = 1'b0;
        tick();
        n_checks++; if (m.sout_valid !== 1'b1 || m.ready !== 1'b0) begin n_fail++; $display("FAIL rst_pre: got valid=%b ready=%b exp 1 0", m.sout_valid, m.ready); end
        #2;
        rst = 1'b0;
        #1;
        n_checks++; if (m.ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b exp 1", m.ready); end
        n_checks++; if (m.sout_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b exp 0", m.sout_valid); end
        n_checks++; if (m.Q !== 4'b0000) begin n_fail++; $display("FAIL rst_Q: got %b exp 0000", m.Q); end
        n_checks++; if (m.sout !== 1'b0) begin n_fail++; $display("FAIL rst_sout: got %b exp 0", m.sout); end
        tick();
        n_checks++; if (m.done !== 1'b0) begin n_fail++; $display("FAIL rst_done_low: got %b exp 0", m.done); end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++; if (m.done !== 1'b0 || m.ready !== 1'b1) begin n_fail++; $display("FAIL rst_after_%0d: got done=%b ready=%b exp 0 1", i, m.done, m.ready); end
        end
    endtask

    task automatic test_msb_first();
        logic [3:0] stream;
        stream = 4'b0101;
        m.D = 4'b0101; m.en = 1'b1;
        tick();
        m.en = 1'b0;
        m.D = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (m.sout_valid !== 1'b1 || m.sout !== stream[3-i]) begin n_fail++; $display("FAIL msb_bit%0d: got valid=%b sout=%b exp 1 %b", i, m.sout_valid, m.sout, stream[3-i]); end
            n_checks++; if (m.Q !== 4'b0101 || m.ready !== 1'b0 || m.done !== 1'b0) begin n_fail++; $display("FAIL msb_stat%0d: got Q=%b ready=%b done=%b exp 0101 0 0", i, m.Q, m.ready, m.done); end
            tick();
        end
        n_checks++; if (m.done !== 1'b1 || m.ready !== 1'b0 || m.sout_valid !== 1'b0 || m.sout !== 1'b0) begin n_fail++; $display("FAIL msb_done: got done=%b ready=%b valid=%b sout=%b exp 1 0 0 0", m.done, m.ready, m.sout_valid, m.sout); end
        tick();
        n_checks++; if (m.ready !== 1'b1 || m.done !== 1'b0 || m.Q !== 4'b0101) begin n_fail++; $display("FAIL msb_ready: got ready=%b done=%b Q=%b exp 1 0 0101", m.ready, m.done, m.Q); end
    endtask

    task automatic test_lsb_first();
        logic [3:0] words [3];
        logic [3:0] streams [3];
        words[0] = 4'b1001; streams[0] = 4'b1001;
        words[1] = 4'b0110; streams[1] = 4'b0110;
        words[2] = 4'b0011; streams[2] = 4'b1100;
        for (int w = 0; w < 3; w++) begin
            l.D = words[w]; l.en = 1'b1;
            tick();
            l.en = 1'b0;
            for (int i = 0; i < 4; i++) begin
                n_checks++; if (l.sout_valid !== 1'b1 || l.sout !== streams[w][3-i]) begin n_fail++; $display("FAIL lsb_w%0d_bit%0d: got valid=%b sout=%b exp 1 %b", w, i, l.sout_valid, l.sout, streams[w][3-i]); end
                tick();
            end
            n_checks++; if (l.done !== 1'b1 || l.Q !== words[w]) begin n_fail++; $display("FAIL lsb_w%0d_done: got done=%b Q=%b exp 1 %b", w, l.done, l.Q, words[w]); end
            tick();
            n_checks++; if (l.ready !== 1'b1) begin n_fail++; $display("FAIL lsb_w%0d_ready: got %b exp 1", w, l.ready); end
        end
    endtask

    task automatic test_hold();
        logic [5:0] exp_sout;
        logic [5:0] exp_valid;
        // cycles k+1..k+6: bit1, held, held, bit2, bit3, bit4
        exp_sout  = 6'b111100;
        exp_valid = 6'b100111;
        m.D = 4'b1100; m.en = 1'b1;
        tick();
        m.en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            m.hold = (i == 1 || i == 2);
            #1;
            n_checks++; if (m.sout !== exp_sout[5-i] || m.sout_valid !== exp_valid[5-i] || m.done !== 1'b0) begin n_fail++; $display("FAIL hold_c%0d: got sout=%b valid=%b done=%b exp %b %b 0", i + 1, m.sout, m.sout_valid, m.done, exp_sout[5-i], exp_valid[5-i]); end
            tick();
        end
        m.hold = 1'b1;
        #1;
        n_checks++; if (m.done !== 1'b1) begin n_fail++; $display("FAIL hold_done: got %b exp 1", m.done); end
        tick();
        n_checks++; if (m.ready !== 1'b1 || m.done !== 1'b0) begin n_fail++; $display("FAIL hold_in_done: got ready=%b done=%b exp 1 0", m.ready, m.done); end
        tick();
        n_checks++; if (m.ready !== 1'b1 || m.sout_valid !== 1'b0) begin n_fail++; $display("FAIL hold_in_idle: got ready=%b valid=%b exp 1 0", m.ready, m.sout_valid); end
        m.hold = 1'b0;
    endtask

    task automatic test_ignored_load();
        logic [3:0] stream;
        stream = 4'b0101;
        m.D = 4'b0101; m.en = 1'b1;
        tick();
        m.en = 1'b0;
        n_checks++; if (m.sout !== 1'b0) begin n_fail++; $display("FAIL ign_bit0: got %b exp 0", m.sout); end
        m.en = 1'b1; m.D = 4'b1111;
        tick();
        for (int i = 1; i < 4; i++) begin
            n_checks++; if (m.sout !== stream[3-i] || m.sout_valid !== 1'b1 || m.Q !== 4'b0101) begin n_fail++; $display("FAIL ign_bit%0d: got sout=%b valid=%b Q=%b exp %b 1 0101", i, m.sout, m.sout_valid, m.Q, stream[3-i]); end
            tick();
        end
        n_checks++; if (m.done !== 1'b1 || m.Q !== 4'b0101) begin n_fail++; $display("FAIL ign_done: got done=%b Q=%b exp 1 0101", m.done, m.Q); end
        tick();
        // en stays high from here: accepts land every 6 cycles
        for (int i = 0; i <= 12; i++) begin
            n_checks++; if (m.ready !== ((i % 6) == 0)) begin n_fail++; $display("FAIL en_held_c%0d: got ready=%b exp %b", i, m.ready, ((i % 6) == 0)); end
            if (i == 1) begin
                n_checks++; if (m.Q !== 4'b1111) begin n_fail++; $display("FAIL en_held_Q: got %b exp 1111", m.Q); end
            end
            if (i == 12) m.en = 1'b0;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] stream;
        logic [7:0] got;
        int         n_valid;
        int         n_done;
        stream  = 8'b1001_0110;
        got     = '0;
        n_valid = 0;
        n_done  = 0;
        m.D = 4'b1001; m.en = 1'b1;
        tick();
        for (int i = 1; i <= 12; i++) begin
            if (m.sout_valid) begin
                if (n_valid < 8) got[7-n_valid] = m.sout;
                n_valid++;
            end
            if (m.done) n_done++;
            if (i == 6) m.D = 4'b0110;
            if (i == 12) begin
                n_checks++; if (m.ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready12: got %b exp 1", m.ready); end
                m.en = 1'b0;
            end
            tick();
        end
        n_checks++; if (n_valid != 8) begin n_fail++; $display("FAIL b2b_nvalid: got %0d exp 8", n_valid); end
        n_checks++; if (n_done != 2) begin n_fail++; $display("FAIL b2b_ndone: got %0d exp 2", n_done); end
        n_checks++; if (got !== stream) begin n_fail++; $display("FAIL b2b_bits: got %b exp %b", got, stream); end
        n_checks++; if (m.Q !== 4'b0110) begin n_fail++; $display("FAIL b2b_Q: got %b exp 0110", m.Q); end
    endtask

    initial begin
        test_reset();
        test_msb_first();
        wait_idle();
        test_lsb_first();
        wait_idle();
        test_hold();
        wait_idle();
        test_ignored_load();
        wait_idle();
        test_back_to_back();
        wait_idle();
        test_reset_mid_shift();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/piso_shift_reader.md
# piso_shift_reader

Parallel-load, serial-unload register that reads a captured WIDTH-bit word out one bit per clock. It is the read side of our loadable registers: a word is captured with the same `D`/`en` load convention, then drained on `sout` with a valid/hold handshake and a done pulse. It sits between a parallel register stage and any bit-serial consumer.

## Interface
- `WIDTH`, default 4: word width in bits; legal range ≥ 2.
- `MSB_FIRST`, default 1: 1 shifts out bit WIDTH-1 first; 0 shifts out bit 0 first.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset; asserted forces reset state immediately.
- `en`  in  1  load request; honoured only while `ready`=1.
- `D`  in  WIDTH  parallel word, sampled on the accepting edge.
- `hold`  in  1  consumer stall; freezes shifting while high.
- `ready`  out  1  block is idle and will accept `en`.
- `sout`  out  1  current serial bit.
- `sout_valid`  out  1  `sout` is a valid bit, consumed on this edge.
- `done`  out  1  one-cycle pulse after the last bit is consumed.
- `Q`  out  WIDTH  copy of the last accepted word; held until next accept.

## Operation
- States: IDLE, SHIFT, DONE. Registers: state, shift register `sr` (WIDTH), bit counter `cnt` (ceil(log2(WIDTH))+1 bits), `Q`.
- IDLE: `ready`=1. On edge with `en`=1: `sr`←D, `Q`←D, `cnt`←0, go SHIFT. `en`=0: stay.
- SHIFT: `sout` = `sr[WIDTH-1]` (MSB_FIRST=1) or `sr[0]` (MSB_FIRST=0); `sout_valid` = !`hold`.
  - Edge with `hold`=0: shift `sr` one position toward the output end, filling with 0; `cnt`←`cnt`+1; if `cnt`=WIDTH-1, go DONE.
  - Edge with `hold`=1: `sr`, `cnt`, and state unchanged.
- DONE: `done`=1, `ready`=0, `sout_valid`=0; next edge unconditionally go IDLE.
- `en` outside IDLE is ignored; it is not queued. `D` changes outside the accepting edge have no effect.
- `Q` changes only on an accepting edge or reset.
- `ready`, `sout_valid`, `done` decode combinationally from state (plus `hold`). `sout` = output end of `sr` in every state, which is 0 in IDLE after completion.

## Timing
- Reset (`rst`=0, asynchronous): state=IDLE, `sr`=0, `cnt`=0, `Q`=0, giving `ready`=1, `sout`=0, `sout_valid`=0, `done`=0. Takes effect without a clock edge. Release is sampled synchronously; the first acceptance is possible on the first rising edge with `rst`=1.
- Reset during SHIFT or DONE aborts the word immediately with no `done` pulse.
- Accept on edge k: the first bit is valid in cycle k+1. With no holds, bits occupy cycles k+1..k+WIDTH, `done` is in cycle k+WIDTH+1, and `ready` returns in cycle k+WIDTH+2.
- Minimum spacing between accepts is WIDTH+2 cycles. Each cycle of `hold`=1 in SHIFT adds one cycle.
- `hold` in IDLE or DONE has no effect. `hold` on the cycle of the last bit delays DONE.
- `en`=1 in the same cycle as `done`=1 is ignored. `en` held high in IDLE is accepted on the first edge.

## Test plan
- Reset: drive `rst`=0 mid-SHIFT, between edges -> `ready`=1, `sout_valid`=0, `Q`=0000 before the next edge; no `done` pulse.
- MSB-first (WIDTH=4): `D`=0101, `en` pulse at edge k -> `sout` reads 0,1,0,1 in cycles k+1..k+4 with `sout_valid`=1; `done`=1 in k+5; `ready`=1 in k+6; `Q`=0101 from k+1.
- LSB-first (MSB_FIRST=0): `D`=1001 -> `sout` reads 1,0,0,1. Then `D`=0110 -> `sout` reads 0,1,1,0.
- Hold: `D`=1100, `hold`=1 for 2 cycles after the first bit -> `sout` stays 1 with `sout_valid`=0 for 2 cycles; the remaining bits are 1,0,0; `done` is 2 cycles later than the no-hold case.
- Ignored load: `en`=1 with `D`=1111 during SHIFT of 0101 -> output stream is unchanged and `Q` stays 0101. `en` held high continuously -> words are accepted every 6 cycles.
- Back-to-back: `D`=1001 then `D`=0110 with `en` asserted from `ready` -> 8 valid bits across 12 cycles, with 2 `done` pulses.
